alu_issue_ctrl: RTL and testbench

Command-issuing controller that sits in front of the 8-bit ALU and drives its operand and opcode inputs. It accepts register-to-register ALU commands over a valid/ready handshake and reads both operands from an internal register file. It presents the operands to the ALU, captures the ALU result and writes it back to the register file. It is the initiator side of the ALU interface; the ALU stays a pure combinational responder.

---
 rtl/alu_issue_ctrl_if.sv | 58 +++++
 rtl/alu_issue_ctrl.sv | 124 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of command, host-load, debug, ALU and writeback signals for alu_issue_ctrl.
// Optional flag outputs exist only when ALU_ISSUE_FLAGS_EN is defined.
interface alu_issue_ctrl_if #(
  parameter int NREGS = 8,
  parameter int DW    = 8
);
  localparam int AW = $clog2(NREGS);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rd;
  logic [AW-1:0] cmd_ra;
  logic [AW-1:0] cmd_rb;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic [DW-1:0] alu_in1;
  logic [DW-1:0] alu_in2;
  logic [2:0]    alu_opcode;
  logic [DW-1:0] alu_out;
  logic          done;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
`ifdef ALU_ISSUE_FLAGS_EN
  logic          flag_z;
  logic          flag_n;
`endif

  // Controller side: initiator towards the ALU, responder to the host.
  modport master (
`ifdef ALU_ISSUE_FLAGS_EN
    output flag_z, flag_n,
`endif
    input  cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb,
    output cmd_ready,
    input  ld_en, ld_addr, ld_data, dbg_addr,
    output dbg_data,
    output alu_in1, alu_in2, alu_opcode,
    input  alu_out,
    output done, wb_rd, wb_data
  );

  modport slave (
`ifdef ALU_ISSUE_FLAGS_EN
    input  flag_z, flag_n,
`endif
    output cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb,
    input  cmd_ready,
    output ld_en, ld_addr, ld_data, dbg_addr,
    input  dbg_data,
    input  alu_in1, alu_in2, alu_opcode,
    output alu_out,
    input  done, wb_rd, wb_data
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues register-to-register commands to a combinational ALU: operand read, execute, writeback.
// Latency 3 edges accept->writeback, one command per 4 cycles; optional flags under ALU_ISSUE_FLAGS_EN.
module alu_issue_ctrl #(
  parameter int NREGS = 8,
  parameter int DW    = 8
) (
  input  logic clk,
  input  logic rst_n,
  alu_issue_ctrl_if.master bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic [1:0] {S_IDLE, S_OPRD, S_EXEC, S_WB} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [2:0]    r_op;
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_ra;
  logic [AW-1:0] r_rb;
  logic [DW-1:0] r_result;
  logic [DW-1:0] r_alu_in1;
  logic [DW-1:0] r_alu_in2;
  logic [2:0]    r_alu_opcode;
  logic          r_done;
  logic [AW-1:0] r_wb_rd;
  logic [DW-1:0] r_wb_data;
  logic [DW-1:0] r_regfile [NREGS];
  logic          w_accept;
  logic          w_wb_we;
  logic          w_ld_we;

  assign bus.cmd_ready  = (r_state == S_IDLE);
  assign w_accept       = bus.cmd_valid && (r_state == S_IDLE);
  assign w_wb_we        = (r_state == S_WB);
  // Writeback has priority over a host load to the same register.
  assign w_ld_we        = bus.ld_en && !(w_wb_we && (bus.ld_addr == r_rd));

  assign bus.alu_in1    = r_alu_in1;
  assign bus.alu_in2    = r_alu_in2;
  assign bus.alu_opcode = r_alu_opcode;
  assign bus.done       = r_done;
  assign bus.wb_rd      = r_wb_rd;
  assign bus.wb_data    = r_wb_data;
  assign bus.dbg_data   = r_regfile[bus.dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_OPRD;
      S_OPRD: w_next = S_EXEC;
      S_EXEC: w_next = S_WB;
      S_WB:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op         <= '0;
      r_rd         <= '0;
      r_ra         <= '0;
      r_rb         <= '0;
      r_result     <= '0;
      r_alu_in1    <= '0;
      r_alu_in2    <= '0;
      r_alu_opcode <= '0;
      r_done       <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
    end else begin
      r_done <= w_wb_we;
      if (w_accept) begin
        r_op <= bus.cmd_op;
        r_rd <= bus.cmd_rd;
        r_ra <= bus.cmd_ra;
        r_rb <= bus.cmd_rb;
      end
      // Operands are read before any same-edge write lands; no forwarding.
      if (r_state == S_OPRD) begin
        r_alu_in1    <= r_regfile[r_ra];
        r_alu_in2    <= r_regfile[r_rb];
        r_alu_opcode <= r_op;
      end
      if (r_state == S_EXEC) r_result <= bus.alu_out;
      if (w_wb_we) begin
        r_wb_rd   <= r_rd;
        r_wb_data <= r_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regfile[i] <= '0;
    end else begin
      if (w_ld_we) r_regfile[bus.ld_addr] <= bus.ld_data;
      if (w_wb_we) r_regfile[r_rd]        <= r_result;
    end
  end

`ifdef ALU_ISSUE_FLAGS_EN
  logic r_flag_z;
  logic r_flag_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
    end else if (w_wb_we) begin
      r_flag_z <= (r_result == '0);
      r_flag_n <= r_result[DW-1];
    end
  end

  assign bus.flag_z = r_flag_z;
  assign bus.flag_n = r_flag_n;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU; flag checks only under ALU_ISSUE_FLAGS_EN.
module tb_alu_issue_ctrl;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  alu_issue_ctrl_if #(.NREGS(8), .DW(8)) bus ();

  alu_issue_ctrl #(.NREGS(8), .DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational ALU.
  always_comb begin
    case (bus.alu_opcode)
      3'b000:  bus.alu_out = bus.alu_in1 + bus.alu_in2;
      3'b001:  bus.alu_out = bus.alu_in1 - bus.alu_in2;
      3'b010:  bus.alu_out = bus.alu_in1 & bus.alu_in2;
      3'b011:  bus.alu_out = bus.alu_in1 ^ bus.alu_in2;
      default: bus.alu_out = bus.alu_in1;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] addr, input logic [7:0] exp);
    bus.dbg_addr = addr;
    #1;
    check(tag, {24'd0, bus.dbg_data}, {24'd0, exp});
  endtask

  task automatic issue(input string tag, input logic [2:0] op, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [2:0] rd,
                       input logic [7:0] e_in1, input logic [7:0] e_in2, input logic [7:0] e_res);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_ra    = ra;
    bus.cmd_rb    = rb;
    bus.cmd_rd    = rd;
    tick();                                   // E0
    bus.cmd_valid = 1'b0;
    check({tag, "_rdy_low"}, {31'd0, bus.cmd_ready}, 32'd0);
    tick();                                   // E1
    check({tag, "_in1"}, {24'd0, bus.alu_in1}, {24'd0, e_in1});
    check({tag, "_in2"}, {24'd0, bus.alu_in2}, {24'd0, e_in2});
    check({tag, "_opc"}, {29'd0, bus.alu_opcode}, {29'd0, op});
    tick();                                   // E2
    check({tag, "_nodone"}, {31'd0, bus.done}, 32'd0);
    tick();                                   // E3
    check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    check({tag, "_wbrd"}, {29'd0, bus.wb_rd}, {29'd0, rd});
    check({tag, "_wbdat"}, {24'd0, bus.wb_data}, {24'd0, e_res});
    check({tag, "_rdy_back"}, {31'd0, bus.cmd_ready}, 32'd1);
    rd_chk({tag, "_rf"}, rd, e_res);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_ra    = '0;
    bus.cmd_rb    = '0;
    bus.cmd_rd    = '0;
    bus.ld_en     = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_data   = '0;
    bus.dbg_addr  = '0;

    repeat (2) tick();
    check("rst_rdy",   {31'd0, bus.cmd_ready}, 32'd1);
    check("rst_in1",   {24'd0, bus.alu_in1}, 32'd0);
    check("rst_in2",   {24'd0, bus.alu_in2}, 32'd0);
    check("rst_opc",   {29'd0, bus.alu_opcode}, 32'd0);
    check("rst_done",  {31'd0, bus.done}, 32'd0);
    check("rst_wbrd",  {29'd0, bus.wb_rd}, 32'd0);
    check("rst_wbdat", {24'd0, bus.wb_data}, 32'd0);
`ifdef ALU_ISSUE_FLAGS_EN
    check("rst_fz", {31'd0, bus.flag_z}, 32'd0);
    check("rst_fn", {31'd0, bus.flag_n}, 32'd0);
`endif
    rd_chk("rst_rf7", 3'd7, 8'h00);
    rst_n = 1'b1;
    tick();

    bus.ld_en = 1'b1; bus.ld_addr = 3'd1; bus.ld_data = 8'h05;
    tick();
    bus.ld_addr = 3'd2; bus.ld_data = 8'h03;
    tick();
    bus.ld_en = 1'b0;
    rd_chk("ld_r1", 3'd1, 8'h05);
    rd_chk("ld_r2", 3'd2, 8'h03);

    issue("add", 3'b000, 3'd1, 3'd2, 3'd3, 8'h05, 8'h03, 8'h08);
    tick();
    check("add_pulse_end", {31'd0, bus.done}, 32'd0);
    check("add_in1_hold",  {24'd0, bus.alu_in1}, 32'h05);

    issue("sub", 3'b001, 3'd2, 3'd1, 3'd4, 8'h03, 8'h05, 8'hFE);
`ifdef ALU_ISSUE_FLAGS_EN
    check("sub_fn", {31'd0, bus.flag_n}, 32'd1);
    check("sub_fz", {31'd0, bus.flag_z}, 32'd0);
`endif
    tick();

    issue("xor_self", 3'b011, 3'd1, 3'd1, 3'd1, 8'h05, 8'h05, 8'h00);
`ifdef ALU_ISSUE_FLAGS_EN
    check("xor_fz", {31'd0, bus.flag_z}, 32'd1);
    check("xor_fn", {31'd0, bus.flag_n}, 32'd0);
`endif
    tick();

    issue("pass", 3'b111, 3'd2, 3'd1, 3'd5, 8'h03, 8'h00, 8'h03);
    tick();

    // Back-to-back with cmd_valid held; r1=0 r2=3 r4=FE.
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'b000; bus.cmd_ra = 3'd2; bus.cmd_rb = 3'd2; bus.cmd_rd = 3'd6;
    tick();                                   // E0
    check("b2b_rdy_e0", {31'd0, bus.cmd_ready}, 32'd0);
    bus.cmd_op = 3'b010; bus.cmd_ra = 3'd2; bus.cmd_rb = 3'd4; bus.cmd_rd = 3'd7;
    tick();                                   // E1
    check("b2b_rdy_e1", {31'd0, bus.cmd_ready}, 32'd0);
    check("b2b_in1_a",  {24'd0, bus.alu_in1}, 32'h03);
    check("b2b_opc_a",  {29'd0, bus.alu_opcode}, 32'd0);
    tick();                                   // E2
    check("b2b_rdy_e2", {31'd0, bus.cmd_ready}, 32'd0);
    bus.ld_en = 1'b1; bus.ld_addr = 3'd6; bus.ld_data = 8'hAA;
    tick();                                   // E3: load collides with writeback
    bus.ld_en = 1'b0;
    check("b2b_done_a",  {31'd0, bus.done}, 32'd1);
    check("b2b_wbdat_a", {24'd0, bus.wb_data}, 32'h06);
    check("b2b_rdy_e3",  {31'd0, bus.cmd_ready}, 32'd1);
    check("b2b_opc_hold", {29'd0, bus.alu_opcode}, 32'd0);
    rd_chk("b2b_wb_wins", 3'd6, 8'h06);
    tick();                                   // E4: second accept
    check("b2b_rdy_e4",  {31'd0, bus.cmd_ready}, 32'd0);
    check("b2b_done_e4", {31'd0, bus.done}, 32'd0);
    tick();                                   // E5
    check("b2b_in1_b", {24'd0, bus.alu_in1}, 32'h03);
    check("b2b_in2_b", {24'd0, bus.alu_in2}, 32'hFE);
    check("b2b_opc_b", {29'd0, bus.alu_opcode}, 32'd2);
    tick();                                   // E6
    bus.ld_en = 1'b1; bus.ld_addr = 3'd0; bus.ld_data = 8'h22;
    tick();                                   // E7: load to a different register
    bus.ld_en = 1'b0;
    bus.cmd_valid = 1'b0;
    check("b2b_done_b",  {31'd0, bus.done}, 32'd1);
    check("b2b_wbrd_b",  {29'd0, bus.wb_rd}, 32'd7);
    check("b2b_wbdat_b", {24'd0, bus.wb_data}, 32'h02);
    rd_chk("b2b_r7", 3'd7, 8'h02);
    rd_chk("b2b_r0", 3'd0, 8'h22);
    tick();
    check("b2b_no_third", {31'd0, bus.cmd_ready}, 32'd1);

    // Reset during EXEC aborts the command.
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'b000; bus.cmd_ra = 3'd2; bus.cmd_rb = 3'd4; bus.cmd_rd = 3'd6;
    tick();                                   // E0
    bus.cmd_valid = 1'b0;
    tick();                                   // E1, now in EXEC
    check("ab_in1", {24'd0, bus.alu_in1}, 32'h03);
    #1;
    rst_n = 1'b0;
    #1;
    check("ab_rdy",   {31'd0, bus.cmd_ready}, 32'd1);
    check("ab_in1_0", {24'd0, bus.alu_in1}, 32'd0);
    check("ab_in2_0", {24'd0, bus.alu_in2}, 32'd0);
    check("ab_wbdat", {24'd0, bus.wb_data}, 32'd0);
    check("ab_wbrd",  {29'd0, bus.wb_rd}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ab_nodone", {31'd0, bus.done}, 32'd0);
    end
    rd_chk("ab_r6", 3'd6, 8'h00);
    rd_chk("ab_r2", 3'd2, 8'h00);
`ifdef ALU_ISSUE_FLAGS_EN
    check("ab_fz", {31'd0, bus.flag_z}, 32'd0);
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ab_post_done", {31'd0, bus.done}, 32'd0);
      check("ab_post_rdy",  {31'd0, bus.cmd_ready}, 32'd1);
    end
    rd_chk("ab_post_r6", 3'd6, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
